multdiv_unit: RTL and testbench
===============================

MULTDIV_UNIT -- requirements
Module: multdiv_unit

Interface
REQ-001 The parameter list SHALL be: WIDTH, 32, operand/result width (only 32 supported).
REQ-002 The port clock SHALL be input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The port reset SHALL be input, 1 bit: synchronous, active-low reset.
REQ-004 The port dx_ir_in SHALL be input, 32 bits: the DX-stage instruction. Opcode is [31:27], rd is [26:22], ALU op is [6:2].
REQ-005 The port dx_write SHALL be input, 1 bit: high in the cycle the DX latch captures a new instruction.
REQ-006 The port flush SHALL be input, 1 bit: pipeline flush; aborts any operation in flight.
REQ-007 The port data_operandA SHALL be input, 32 bits: rs value, post-bypass.
REQ-008 The port data_operandB SHALL be input, 32 bits: rt value, post-bypass.
REQ-009 The port multdiv_is_running SHALL be output, 1 bit: high while an operation iterates.
REQ-010 The port multdiv_result_ready SHALL be output, 1 bit: one-cycle pulse when the result is valid.
REQ-011 The port multdiv_result SHALL be output, 32 bits: product low word or quotient.
REQ-012 The port multdiv_exception SHALL be output, 1 bit: overflow or divide-by-zero; valid with multdiv_result.
REQ-013 The port multdiv_rd SHALL be output, 5 bits: destination register of the latched instruction.

Function
REQ-014 The decode SHALL be: is_mult = opcode 00000 and ALU op 00110; is_div = opcode 00000 and ALU op 00111; is_md = is_mult or is_div.
REQ-015 An armed flag SHALL be set on the edge where dx_write=1, cleared on start, and cleared on flush.
REQ-016 The states SHALL be IDLE, BUSY and DONE.
REQ-017 IDLE->BUSY SHALL occur when armed=1, is_md=1 and flush=0. On that edge the unit latches operandA, operandB, the op type and rd, and clears the iteration counter to 0.
REQ-018 In BUSY the unit SHALL perform one iteration per cycle and increment a 5-bit counter. When the counter reaches 31 (the 32nd iteration), the next state is DONE.
REQ-019 In DONE multdiv_result_ready SHALL be 1 for exactly one cycle, then the state returns to IDLE unconditionally.
REQ-020 multdiv_is_running SHALL be 1 exactly while the state is BUSY and 0 otherwise; it is a registered state decode.
REQ-021 Latency SHALL be fixed: start edge at T, is_running high T+1..T+32, result_ready high T+33, for every operand value including divide-by-zero.
REQ-022 Multiply SHALL be signed 32x32 producing a 64-bit product via a sequential shift-add/Booth datapath. Result = low 32 bits. Exception = 1 if product[63:32] is not the sign extension of product[31].
REQ-023 Divide SHALL be signed, with the quotient truncated toward zero via an iterative restoring or non-restoring datapath on magnitudes, then sign correction. The remainder is discarded.
REQ-024 Divide by zero SHALL give result 0 and exception 1.
REQ-025 0x80000000 / 0xFFFFFFFF SHALL give result 0x80000000 and exception 1.
REQ-026 multdiv_result, multdiv_exception and multdiv_rd SHALL hold their last values after DONE until the next start edge, and SHALL not change during BUSY.
REQ-027 flush=1 in BUSY or DONE SHALL force IDLE on the next edge. No result_ready pulse is issued, and held outputs keep their prior values.
REQ-028 When flush is asserted on the final BUSY iteration, flush SHALL win and no result_ready is issued.
REQ-029 When flush and a start condition coincide in IDLE, there SHALL be no start and armed SHALL clear.
REQ-030 dx_write during BUSY or DONE SHALL only set armed and SHALL not disturb the current operation.
REQ-031 A mult/div still present in DX after DONE without a new dx_write SHALL NOT restart, because armed=0.
REQ-032 Back-to-back identical instructions SHALL restart when dx_write reloads DX.
REQ-033 A non-md instruction with armed=1 in IDLE SHALL leave the unit in IDLE with armed held.

Reset
REQ-034 When reset=0 at a rising edge, the unit SHALL enter IDLE and clear armed, the counter and all datapath registers, with priority over all other inputs including mid-operation.
REQ-035 Reset values SHALL be: multdiv_is_running=0, multdiv_result_ready=0, multdiv_result=0x00000000, multdiv_exception=0, multdiv_rd=0.

Verification
REQ-036 Mult 7 x 0xFFFFFFFA, rd=5 -> is_running high 32 cycles, ready at T+33, result 0xFFFFFFD6, exception 0, rd 5.
REQ-037 Mult 0x00010000 x 0x00010000 -> result 0x00000000, exception 1. Mult 0xFFFFFFFF x 0xFFFFFFFF -> result 1, exception 0.
REQ-038 Div 0xFFFFFFF9 / 2 -> result 0xFFFFFFFD, exception 0. Div 5 / 0 -> result 0, exception 1, ready still at T+33.
REQ-039 Div 0x80000000 / 0xFFFFFFFF -> result 0x80000000, exception 1.
REQ-040 Flush at BUSY cycle 10 -> is_running 0 next cycle, no ready, prior result held. reset=0 at BUSY cycle 20 -> all outputs 0 next cycle.
REQ-041 Mult held in DX past DONE without dx_write -> a single ready pulse only. A dx_write reloading the same mult -> second start and ready 33 cycles later.

Source files
------------

// File: rtl/multdiv_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | multdiv_unit: iterative signed 32-bit multiply (Booth) / divide unit    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      dx_ir_in,
  input  logic             dx_write,
  input  logic             flush,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic             multdiv_is_running,
  output logic             multdiv_result_ready,
  output logic [WIDTH-1:0] multdiv_result,
  output logic             multdiv_exception,
  output logic [4:0]       multdiv_rd
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             armed;
  logic [4:0]       count;
  logic             op_div;
  logic [4:0]       rd_latched;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] mq;
  logic             qm1;
  logic [WIDTH-1:0] opb;
  logic             div_zero;
  logic             div_ovf;
  logic             div_neg;

  logic             is_mult;
  logic             is_div;
  logic             start;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             unused_ir_bits;

  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic [WIDTH:0]   acc_next;
  logic [WIDTH-1:0] mq_next;
  logic [WIDTH-1:0] final_result;
  logic             final_exc;

  assign is_mult = (dx_ir_in[31:27] == 5'b00000) && (dx_ir_in[6:2] == 5'b00110);
  assign is_div  = (dx_ir_in[31:27] == 5'b00000) && (dx_ir_in[6:2] == 5'b00111);
  assign start   = (state == IDLE) && armed && (is_mult || is_div) && !flush;
  assign abs_a   = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign abs_b   = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  assign unused_ir_bits = ^{dx_ir_in[21:7], dx_ir_in[1:0]};

  assign multdiv_is_running   = (state == BUSY);
  assign multdiv_result_ready = (state == DONE) && !flush;

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = BUSY;
      BUSY: begin
        if (flush)               next_state = IDLE;
        else if (count == 5'd31) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Multiply: radix-2 Booth over {acc, mq, qm1}; divide: restoring on magnitudes (acc=remainder, mq=quotient).
  always_comb begin
    booth_sum = acc;
    rem_shift = {acc[WIDTH-1:0], mq[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, opb};
    acc_next  = acc;
    mq_next   = mq;
    if (op_div) begin
      if (!rem_diff[WIDTH]) begin
        acc_next = rem_diff;
        mq_next  = {mq[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = rem_shift;
        mq_next  = {mq[WIDTH-2:0], 1'b0};
      end
    end else begin
      case ({mq[0], qm1})
        2'b01:   booth_sum = acc + {opb[WIDTH-1], opb};
        2'b10:   booth_sum = acc - {opb[WIDTH-1], opb};
        default: booth_sum = acc;
      endcase
      acc_next = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
      mq_next  = {booth_sum[0], mq[WIDTH-1:1]};
    end
  end

  always_comb begin
    final_result = mq_next;
    final_exc    = (acc_next[WIDTH-1:0] != {WIDTH{mq_next[WIDTH-1]}});
    if (op_div) begin
      final_result = div_zero ? '0 : (div_neg ? -mq_next : mq_next);
      final_exc    = div_zero || div_ovf;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) armed <= 1'b0;
    else if (flush)    armed <= 1'b0;
    else if (dx_write) armed <= 1'b1;
    else if (start)    armed <= 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count             <= '0;
      op_div            <= 1'b0;
      rd_latched        <= '0;
      acc               <= '0;
      mq                <= '0;
      qm1               <= 1'b0;
      opb               <= '0;
      div_zero          <= 1'b0;
      div_ovf           <= 1'b0;
      div_neg           <= 1'b0;
      multdiv_result    <= '0;
      multdiv_exception <= 1'b0;
      multdiv_rd        <= '0;
    end else if (start) begin
      count      <= '0;
      op_div     <= is_div;
      rd_latched <= dx_ir_in[26:22];
      acc        <= '0;
      qm1        <= 1'b0;
      mq         <= is_div ? abs_a : data_operandA;
      opb        <= is_div ? abs_b : data_operandB;
      div_zero   <= is_div && (data_operandB == '0);
      div_ovf    <= is_div && (data_operandA == {1'b1, {(WIDTH-1){1'b0}}})
                           && (data_operandB == {WIDTH{1'b1}});
      div_neg    <= is_div && (data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1]);
    end else if (state == BUSY && !flush) begin
      acc   <= acc_next;
      mq    <= mq_next;
      qm1   <= mq[0];
      count <= count + 5'd1;
      // Outputs only move on the final iteration so they stay stable throughout BUSY.
      if (count == 5'd31) begin
        multdiv_result    <= final_result;
        multdiv_exception <= final_exc;
        multdiv_rd        <= rd_latched;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multdiv_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_multdiv_unit: randomized self-checking bench with arithmetic model   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] dx_ir_in = '0;
  logic        dx_write = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic        multdiv_is_running;
  logic        multdiv_result_ready;
  logic [31:0] multdiv_result;
  logic        multdiv_exception;
  logic [4:0]  multdiv_rd;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_result = '0;
  logic        exp_exc = 1'b0;
  logic [4:0]  exp_rd = '0;

  multdiv_unit #(.WIDTH(32)) dut (
    .clock               (clock),
    .reset               (reset),
    .dx_ir_in            (dx_ir_in),
    .dx_write            (dx_write),
    .flush               (flush),
    .data_operandA       (data_operandA),
    .data_operandB       (data_operandB),
    .multdiv_is_running  (multdiv_is_running),
    .multdiv_result_ready(multdiv_result_ready),
    .multdiv_result      (multdiv_result),
    .multdiv_exception   (multdiv_exception),
    .multdiv_rd          (multdiv_rd)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] make_ir(input bit is_div, input logic [4:0] rd);
    logic [31:0] ir;
    ir        = '0;
    ir[26:22] = rd;
    ir[6:2]   = is_div ? 5'b00111 : 5'b00110;
    return ir;
  endfunction

  // Reference: plain signed 64-bit arithmetic.
  task automatic model(input bit is_div, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] res, output logic exc);
    longint p;
    if (!is_div) begin
      p   = longint'($signed(x)) * longint'($signed(y));
      res = p[31:0];
      exc = (p != longint'($signed(p[31:0])));
    end else if (y == 32'd0) begin
      res = '0;
      exc = 1'b1;
    end else begin
      p   = longint'($signed(x)) / longint'($signed(y));
      res = p[31:0];
      exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end
  endtask

  task automatic load(input logic [31:0] ir, input logic [31:0] x, input logic [31:0] y);
    @(negedge clock);
    dx_ir_in      = ir;
    data_operandA = x;
    data_operandB = y;
    dx_write      = 1'b1;
    @(negedge clock);
    dx_write      = 1'b0;
  endtask

  task automatic idle_check(input int n, input string tag);
    int act;
    act = 0;
    repeat (n) begin
      @(negedge clock);
      if (multdiv_is_running || multdiv_result_ready) act++;
    end
    check(tag, act, 0);
  endtask

  // Called when the next rising edge is the start edge.
  task automatic run(input bit is_div, input logic [31:0] x, input logic [31:0] y,
                     input logic [4:0] rd, input int flush_at, input int wr_at, input string tag);
    logic [31:0] er;
    logic        ee;
    int          cycles;
    int          running;
    bit          seen;
    model(is_div, x, y, er, ee);
    cycles  = 0;
    running = 0;
    seen    = 0;
    while (cycles < 40) begin
      @(negedge clock);
      cycles++;
      if (multdiv_is_running) running++;
      if (multdiv_result_ready) seen = 1;
      if (cycles == 16) begin
        check({tag, " busy_hold_result"}, multdiv_result, exp_result);
        check({tag, " busy_hold_rd"}, multdiv_rd, exp_rd);
      end
      if (flush_at > 0 && cycles == flush_at + 1) break;
      if (seen) break;
      dx_write = (cycles == wr_at);
      flush    = (flush_at > 0 && cycles == flush_at);
    end
    dx_write = 1'b0;
    flush    = 1'b0;
    if (flush_at > 0) begin
      check({tag, " flush_running"}, multdiv_is_running, 1'b0);
      check({tag, " flush_ready"}, seen, 1'b0);
      check({tag, " flush_hold_result"}, multdiv_result, exp_result);
      check({tag, " flush_hold_exc"}, multdiv_exception, exp_exc);
    end else begin
      check({tag, " ready_cycle"}, cycles, 33);
      check({tag, " running_cycles"}, running, 32);
      check({tag, " result"}, multdiv_result, er);
      check({tag, " exception"}, multdiv_exception, ee);
      check({tag, " rd"}, multdiv_rd, rd);
      exp_result = er;
      exp_exc    = ee;
      exp_rd     = rd;
      @(negedge clock);
      check({tag, " ready_single"}, multdiv_result_ready, 1'b0);
    end
  endtask

  initial begin
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  rd;
    bit          dv;
    int          sel;

    repeat (3) @(negedge clock);
    check("reset running", multdiv_is_running, 1'b0);
    check("reset ready", multdiv_result_ready, 1'b0);
    check("reset result", multdiv_result, 32'h0);
    check("reset exception", multdiv_exception, 1'b0);
    check("reset rd", multdiv_rd, 5'd0);
    reset = 1'b1;

    load(make_ir(0, 5'd5), 32'd7, 32'hFFFFFFFA);
    run(0, 32'd7, 32'hFFFFFFFA, 5'd5, 0, 0, "mult7");
    idle_check(40, "held_in_dx_no_restart");
    load(make_ir(0, 5'd5), 32'd7, 32'hFFFFFFFA);
    run(0, 32'd7, 32'hFFFFFFFA, 5'd5, 0, 0, "mult7_reload");

    load(make_ir(0, 5'd1), 32'h00010000, 32'h00010000);
    run(0, 32'h00010000, 32'h00010000, 5'd1, 0, 0, "mult_ovf");
    load(make_ir(0, 5'd2), 32'hFFFFFFFF, 32'hFFFFFFFF);
    run(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 0, 0, "mult_m1m1");
    load(make_ir(1, 5'd3), 32'hFFFFFFF9, 32'd2);
    run(1, 32'hFFFFFFF9, 32'd2, 5'd3, 0, 0, "div_neg7_2");
    load(make_ir(1, 5'd4), 32'd5, 32'd0);
    run(1, 32'd5, 32'd0, 5'd4, 0, 0, "div_by_zero");
    load(make_ir(1, 5'd6), 32'h80000000, 32'hFFFFFFFF);
    run(1, 32'h80000000, 32'hFFFFFFFF, 5'd6, 0, 0, "div_min_m1");

    load(make_ir(1, 5'd9), 32'd100, 32'd7);
    run(1, 32'd100, 32'd7, 5'd9, 10, 0, "flush_c10");
    idle_check(40, "flush_c10 quiet");
    load(make_ir(0, 5'd10), 32'd123, 32'd456);
    run(0, 32'd123, 32'd456, 5'd10, 32, 0, "flush_last");
    idle_check(40, "flush_last quiet");

    // Flush coinciding with the start edge: no start, armed dropped.
    @(negedge clock);
    dx_ir_in = make_ir(0, 5'd11);
    data_operandA = 32'd3;
    data_operandB = 32'd4;
    dx_write = 1'b1;
    @(negedge clock);
    dx_write = 1'b0;
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    idle_check(40, "flush_at_start");

    // dx_write mid-operation re-arms, giving a second run right after DONE.
    load(make_ir(0, 5'd12), 32'hFFFF0001, 32'd65537);
    run(0, 32'hFFFF0001, 32'd65537, 5'd12, 0, 5, "wr_in_busy");
    run(0, 32'hFFFF0001, 32'd65537, 5'd12, 0, 0, "wr_in_busy_restart");

    // Non-md instruction keeps armed; swapping in a mult then starts it.
    load(32'h08000018, 32'd9, 32'd9);
    idle_check(5, "non_md_idle");
    dx_ir_in = make_ir(0, 5'd13);
    run(0, 32'd9, 32'd9, 5'd13, 0, 0, "armed_held");

    load(make_ir(1, 5'd14), 32'd1000, 32'd3);
    repeat (20) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("midreset running", multdiv_is_running, 1'b0);
    check("midreset ready", multdiv_result_ready, 1'b0);
    check("midreset result", multdiv_result, 32'h0);
    check("midreset exception", multdiv_exception, 1'b0);
    check("midreset rd", multdiv_rd, 5'd0);
    reset = 1'b1;
    exp_result = '0;
    exp_exc    = 1'b0;
    exp_rd     = '0;
    idle_check(40, "midreset quiet");

    for (int i = 0; i < 16; i++) begin
      dv  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 7);
      x   = $urandom;
      y   = $urandom;
      rd  = 5'($urandom);
      if (sel == 0) y = 32'd0;
      if (sel == 1) begin
        x = 32'h80000000;
        y = 32'hFFFFFFFF;
      end
      if (sel == 2) y = 32'($urandom_range(1, 20));
      if (sel == 3) x = 32'($signed(-$urandom_range(1, 1000)));
      load(make_ir(dv, rd), x, y);
      run(dv, x, y, rd, 0, 0, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
